// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register bank: word type, lane limits, register modes.
package regfile_pkg;

  localparam int unsigned WordBits  = 32;
  localparam int unsigned WordBytes = WordBits / 8;
  localparam int unsigned MaxLanes  = 8;

  typedef logic [WordBits-1:0] word_t;

  typedef enum logic [1:0] {
    RegRw,
    RegPulse,
    RegW1c
  } reg_mode_e;

  // Expand per-byte enables into a per-bit mask.
  function automatic word_t byte_mask(input logic [WordBytes-1:0] be);
    word_t m;
    m = '0;
    for (int b = 0; b < WordBytes; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_rd_pipe.sv
// Read data pipeline: captures a read beat on valid_i and presents it Lat cycles later,
// holding the last returned beat until the next one arrives.
module regfile_rd_pipe #(
  parameter int unsigned Width = 32,
  parameter int unsigned Lat   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic             tap_vld;
  logic [Width-1:0] tap_dat;
  logic [Width-1:0] out_q;

  if (Lat > 1) begin : g_stage
    logic             vld_q;
    logic [Width-1:0] dat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= valid_i;
        if (valid_i) begin
          dat_q <= data_i;
        end
      end
    end

    assign tap_vld = vld_q;
    assign tap_dat = dat_q;
  end else begin : g_bypass
    assign tap_vld = valid_i;
    assign tap_dat = data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (tap_vld) begin
      out_q <= tap_dat;
    end
  end

  assign data_o = out_q;

endmodule

// File: rtl/regfile_bank.sv
// Multi-lane register bank with RW, pulse and write-1-to-clear registers, externally supplied
// read values, a latency-configurable read path and a registered interrupt output.
module regfile_bank #(
  parameter int unsigned           NADDR        = 4,
  parameter int unsigned           NLANES       = 4,
  parameter int unsigned           RD_LAT       = 1,
  parameter logic [31:0]           INIT_REG     = '0,
  parameter logic [(2**NADDR)-1:0] PULSE_MASK   = '0,
  parameter logic [(2**NADDR)-1:0] W1C_MASK     = '0,
  parameter int unsigned           IRQ_STAT_IDX = 3,
  parameter int unsigned           IRQ_EN_IDX   = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          en,
  input  logic [4*NLANES-1:0]           we,
  input  logic [15:0]                   addr,
  input  logic [32*NLANES-1:0]          wr_data,
  output logic [32*NLANES-1:0]          rd_data,
  output logic [32*(2**NADDR)-1:0]      reg_val,
  output logic [32*(2**NADDR)-1:0]      pul_val,
  input  logic [32*(2**NADDR)-1:0]      read_val,
  input  logic [32*(2**NADDR)-1:0]      hw_set,
  output logic                          irq
);

  import regfile_pkg::*;

  localparam int unsigned NREGS = 2**NADDR;
  localparam int unsigned Lanes = (NLANES > MaxLanes) ? MaxLanes : NLANES;
  localparam logic [NADDR-1:0] LaneMsk = NADDR'(Lanes - 1);

  // Pulse mode takes precedence if a register is flagged in both masks.
  function automatic reg_mode_e mode_of(input int r);
    if (PULSE_MASK[r]) return RegPulse;
    if (W1C_MASK[r]) return RegW1c;
    return RegRw;
  endfunction

  function automatic word_t reset_val(input int r);
    return (mode_of(r) == RegRw) ? word_t'(INIT_REG) : '0;
  endfunction

  word_t reg_q [NREGS];
  word_t reg_d [NREGS];
  word_t pul_q [NREGS];
  word_t pul_d [NREGS];
  logic  irq_q;

  logic [WordBytes-1:0] wr_be  [NREGS];
  word_t                wr_dat [NREGS];

  logic [NADDR-1:0]     idx;
  logic [NADDR-1:0]     base;
  logic [NADDR-1:0]     lane_idx [Lanes];
  logic [32*NLANES-1:0] rd_sel;

  // Upper address bits alias onto the register space.
  logic unused_addr;
  assign unused_addr = ^{addr[15:NADDR+2], addr[1:0]};

  assign idx  = addr[NADDR+1:2];
  assign base = idx & ~LaneMsk;

  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    assign lane_idx[k]          = base + NADDR'(k);
    assign rd_sel[32*k +: 32]   = read_val[32*lane_idx[k] +: 32];
  end

  if (NLANES > Lanes) begin : g_rd_pad
    assign rd_sel[32*NLANES-1:32*Lanes] = '0;
  end

  // Scatter the beat onto per-register byte enables and data.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_be[r]  = '0;
      wr_dat[r] = '0;
    end
    for (int k = 0; k < Lanes; k++) begin
      wr_be[lane_idx[k]]  = en ? we[4*k +: 4] : '0;
      wr_dat[lane_idx[k]] = wr_data[32*k +: 32];
    end
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      reg_d[r] = reg_q[r];
      pul_d[r] = '0;
      unique case (mode_of(r))
        RegRw: begin
          reg_d[r] = (reg_q[r] & ~byte_mask(wr_be[r])) | (wr_dat[r] & byte_mask(wr_be[r]));
        end
        RegPulse: begin
          reg_d[r] = '0;
          pul_d[r] = wr_dat[r] & byte_mask(wr_be[r]);
        end
        RegW1c: begin
          // Set is applied after clear so a coincident hardware event wins.
          reg_d[r] = (reg_q[r] & ~(wr_dat[r] & byte_mask(wr_be[r]))) | hw_set[32*r +: 32];
        end
        default: reg_d[r] = reg_q[r];
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int r = 0; r < NREGS; r++) begin
        reg_q[r] <= reset_val(r);
        pul_q[r] <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        reg_q[r] <= reg_d[r];
        pul_q[r] <= pul_d[r];
      end
      irq_q <= |(reg_q[IRQ_STAT_IDX] & reg_q[IRQ_EN_IDX]);
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_out
    assign reg_val[32*r +: 32] = reg_q[r];
    assign pul_val[32*r +: 32] = pul_q[r];
  end

  assign irq = irq_q;

  regfile_rd_pipe #(
    .Width(32*NLANES),
    .Lat  (RD_LAT)
  ) u_rd_pipe (
    .clk_i  (axi_aclk),
    .rst_ni (axi_aresetn),
    .valid_i(en),
    .data_i (rd_sel),
    .data_o (rd_data)
  );

endmodule

// File: tb/tb_regfile_bank.sv
// Randomized bench for regfile_bank against a behavioural per-register model.
module tb_regfile_bank;

  localparam int NA  = 4;
  localparam int NR  = 16;
  localparam int NL  = 4;
  localparam int LAT = 2;
  localparam logic [31:0] INIT  = 32'h0;
  localparam logic [15:0] PMASK = 16'h2020;
  localparam logic [15:0] WMASK = 16'h1008;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [15:0]  we;
  logic [15:0]  addr;
  logic [127:0] wr_data;
  logic [127:0] rd_data;
  logic [511:0] reg_val;
  logic [511:0] pul_val;
  logic [511:0] read_val;
  logic [511:0] hw_set;
  logic         irq;

  regfile_bank #(
    .NADDR       (NA),
    .NLANES      (NL),
    .RD_LAT      (LAT),
    .INIT_REG    (INIT),
    .PULSE_MASK  (PMASK),
    .W1C_MASK    (WMASK),
    .IRQ_STAT_IDX(3),
    .IRQ_EN_IDX  (4)
  ) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .en         (en),
    .we         (we),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .reg_val    (reg_val),
    .pul_val    (pul_val),
    .read_val   (read_val),
    .hw_set     (hw_set),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;
  bit rv_rand = 1'b0;

  // Behavioural model state
  logic [31:0]  m_reg [NR];
  logic [31:0]  m_pul [NR];
  logic [127:0] m_rd;
  logic         m_irq;
  typedef struct {
    int           due;
    logic [127:0] d;
  } rd_t;
  rd_t rq[$];
  int  cyc;

  // 0 = read/write, 1 = pulse, 2 = write-1-to-clear
  function automatic int kind(input int r);
    if (PMASK[r]) return 1;
    if (WMASK[r]) return 2;
    return 0;
  endfunction

  function automatic logic [511:0] pack_reg();
    logic [511:0] x;
    for (int r = 0; r < NR; r++) x[32*r +: 32] = m_reg[r];
    return x;
  endfunction

  function automatic logic [511:0] pack_pul();
    logic [511:0] x;
    for (int r = 0; r < NR; r++) x[32*r +: 32] = m_pul[r];
    return x;
  endfunction

  function automatic logic [511:0] at(input int r, input logic [31:0] v);
    logic [511:0] x;
    x = '0;
    x[32*r +: 32] = v;
    return x;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: updated on every clock edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) begin
          m_reg[r] = (kind(r) == 0) ? INIT : 32'h0;
          m_pul[r] = 32'h0;
        end
        m_rd  = '0;
        m_irq = 1'b0;
        rq.delete();
        cyc = 0;
      end else begin
        int idx;
        int base;
        int t;
        logic [31:0]  bm;
        logic [127:0] smp;
        cyc++;
        m_irq = |(m_reg[3] & m_reg[4]);
        for (int r = 0; r < NR; r++) m_pul[r] = 32'h0;
        if (en) begin
          idx  = (int'(addr) >> 2) % NR;
          base = idx - (idx % NL);
          for (int k = 0; k < NL; k++) begin
            t = (base + k) % NR;
            smp[32*k +: 32] = read_val[32*t +: 32];
          end
          rq.push_back('{due: cyc + LAT - 1, d: smp});
          for (int k = 0; k < NL; k++) begin
            t  = (base + k) % NR;
            bm = 32'h0;
            for (int b = 0; b < 4; b++) if (we[4*k+b]) bm[8*b +: 8] = 8'hFF;
            case (kind(t))
              0: m_reg[t] = (m_reg[t] & ~bm) | (wr_data[32*k +: 32] & bm);
              1: m_pul[t] = wr_data[32*k +: 32] & bm;
              default: m_reg[t] = m_reg[t] & ~(wr_data[32*k +: 32] & bm);
            endcase
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (kind(r) == 2) m_reg[r] = m_reg[r] | hw_set[32*r +: 32];
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
          m_rd = rq[0].d;
          void'(rq.pop_front());
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("cyc_rd_data", 512'(rd_data), 512'(m_rd));
        chk("cyc_reg_val", reg_val, pack_reg());
        chk("cyc_pul_val", pul_val, pack_pul());
        chk("cyc_irq", 512'(irq), 512'(m_irq));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic e, input logic [15:0] w, input logic [15:0] a,
                     input logic [127:0] d, input logic [511:0] hs);
    en      = e;
    we      = w;
    addr    = a;
    wr_data = d;
    hw_set  = hs;
    if (rv_rand) begin
      for (int r = 0; r < NR; r++) read_val[32*r +: 32] = $urandom();
    end else begin
      read_val = pack_reg();
    end
  endtask

  task automatic idle();
    put(1'b0, 16'h0, 16'h0, 128'h0, 512'h0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [511:0] hs;
    en = 1'b0; we = '0; addr = '0; wr_data = '0; hw_set = '0; read_val = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    cmp_on = 1'b1;
    chk("rst_reg_val", reg_val, 512'h0);
    chk("rst_rd_data", 512'(rd_data), 512'h0);
    chk("rst_pul_val", pul_val, 512'h0);
    chk("rst_irq", 512'(irq), 512'h0);
    rst_n = 1'b1;
    tick();

    // Byte enable on reg 0
    put(1'b1, 16'h0002, 16'h0000, {96'h0, 32'hAABBCCDD}, '0);
    tick(); idle();
    chk("byte_en_reg0", 512'(reg_val[31:0]), 512'h0000CC00);

    // Full beat at 0x10 spans RW regs 4,6,7 and pulse reg 5
    put(1'b1, 16'hFFFF, 16'h0010, {32'd4, 32'd3, 32'd2, 32'd1}, '0);
    tick(); idle();
    chk("beat10_reg4", 512'(reg_val[159:128]), 512'd1);
    chk("beat10_reg5", 512'(reg_val[191:160]), 512'd0);
    chk("beat10_reg67", 512'(reg_val[255:192]), 512'h00000004_00000003);
    chk("beat10_pul5", 512'(pul_val[191:160]), 512'd2);
    tick();
    chk("beat10_pul5_gone", 512'(pul_val[191:160]), 512'd0);

    // Full beat at 0x20 into RW regs 8..11, then read back with loopback read_val
    put(1'b1, 16'hFFFF, 16'h0020, {32'd4, 32'd3, 32'd2, 32'd1}, '0);
    tick(); idle();
    chk("beat20_regs", 512'(reg_val[383:256]), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
    put(1'b1, 16'h0000, 16'h0020, 128'h0, '0);
    tick(); idle();
    tick();
    chk("read_back", 512'(rd_data), 512'({32'd4, 32'd3, 32'd2, 32'd1}));

    // Upper address bits alias
    put(1'b1, 16'h000F, 16'hF020, {96'h0, 32'h55}, '0);
    tick(); idle();
    chk("alias_reg8", 512'(reg_val[287:256]), 512'h55);

    // Pulse register 5
    put(1'b1, 16'h00F0, 16'h0014, {32'h0, 32'h0, 32'h81, 32'h0}, '0);
    tick(); idle();
    chk("pulse5_on", 512'(pul_val[191:160]), 512'h81);
    chk("pulse5_reg", 512'(reg_val[191:160]), 512'h0);
    tick();
    chk("pulse5_off", 512'(pul_val[191:160]), 512'h0);

    // W1C register 3
    put(1'b0, 16'h0, 16'h0, 128'h0, at(3, 32'h4));
    tick(); idle();
    chk("w1c_set", 512'(reg_val[127:96]), 512'h4);
    tick();
    chk("w1c_sticky", 512'(reg_val[127:96]), 512'h4);
    put(1'b1, 16'hF000, 16'h000C, {32'h4, 96'h0}, at(3, 32'h4));
    tick(); idle();
    chk("w1c_set_wins", 512'(reg_val[127:96]), 512'h4);
    put(1'b1, 16'hF000, 16'h000C, {32'h4, 96'h0}, '0);
    tick(); idle();
    chk("w1c_clear", 512'(reg_val[127:96]), 512'h0);

    // Interrupt
    put(1'b1, 16'h000F, 16'h0010, {96'h0, 32'h4}, '0);
    tick(); idle();
    chk("irq_en_reg", 512'(reg_val[159:128]), 512'h4);
    put(1'b0, 16'h0, 16'h0, 128'h0, at(3, 32'h4));
    tick(); idle();
    chk("irq_stat_set", 512'(reg_val[127:96]), 512'h4);
    chk("irq_not_yet", 512'(irq), 512'h0);
    tick();
    chk("irq_raised", 512'(irq), 512'h1);
    put(1'b1, 16'hF000, 16'h000C, {32'h4, 96'h0}, '0);
    tick(); idle();
    chk("irq_stat_clr", 512'(reg_val[127:96]), 512'h0);
    chk("irq_still", 512'(irq), 512'h1);
    tick();
    chk("irq_dropped", 512'(irq), 512'h0);

    // Randomized traffic
    rv_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      hs = '0;
      if ($urandom_range(0, 3) == 0) begin
        for (int r = 0; r < NR; r++) hs[32*r +: 32] = $urandom() & $urandom() & $urandom();
      end
      put(($urandom_range(0, 3) != 0), 16'($urandom()), 16'($urandom()),
          {$urandom(), $urandom(), $urandom(), $urandom()}, hs);
      tick();
    end
    rv_rand = 1'b0;
    idle();
    tick();

    // Reset during an in-flight RD_LAT=2 read
    put(1'b1, 16'hFFFF, 16'h0020, {32'd4, 32'd3, 32'd2, 32'd1}, '0);
    tick();
    put(1'b1, 16'h0000, 16'h0020, 128'h0, '0);
    tick(); idle();
    #2 rst_n = 1'b0;
    tick();
    chk("rst_mid_rd_data", 512'(rd_data), 512'h0);
    chk("rst_mid_reg_val", reg_val, 512'h0);
    chk("rst_mid_pul_val", pul_val, 512'h0);
    chk("rst_mid_irq", 512'(irq), 512'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_rd", 512'(rd_data), 512'h0);
    end
    put(1'b1, 16'h000F, 16'h0020, {96'h0, 32'h77}, '0);
    tick();
    put(1'b1, 16'h0000, 16'h0020, 128'h0, '0);
    tick(); idle();
    tick();
    chk("post_rst_reg8", 512'(reg_val[287:256]), 512'h77);
    chk("post_rst_read", 512'(rd_data), 512'h77);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 SHALL have parameter NADDR, default 4, log2 of register count; NREGS = 2**NADDR 32-bit registers.
REQ-002 SHALL have parameter NLANES, default 4, 32-bit lanes per port beat (1, 2, 4 or 8); port data width = 32*NLANES.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (1 or 2).
REQ-004 SHALL have parameter INIT_REG, default 0, 32-bit reset value of every RW register.
REQ-005 SHALL have parameters PULSE_MASK and W1C_MASK, default 0, NREGS-bit masks selecting pulse-mode and write-1-to-clear registers.
REQ-006 SHALL have parameters IRQ_STAT_IDX (default 3) and IRQ_EN_IDX (default 4), register indices of interrupt status and enable.
REQ-007 axi_aclk  in  1  single clock; all logic on rising edge.
REQ-008 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-009 en  in  1  port access strobe.
REQ-010 we  in  4*NLANES  byte write enables; bit 4k+b = byte b of lane k.
REQ-011 addr  in  16  byte address; register index = addr[NADDR+1:2].
REQ-012 wr_data  in  32*NLANES  write data, lane k in bits [32k+31:32k].
REQ-013 rd_data  out  32*NLANES  read data.
REQ-014 reg_val  out  NREGS x 32  current stored register contents.
REQ-015 pul_val  out  NREGS x 32  one-cycle write pulses.
REQ-016 read_val  in  NREGS x 32  value returned on read per register.
REQ-017 hw_set  in  NREGS x 32  hardware set strobes for W1C registers.
REQ-018 irq  out  1  registered interrupt request.

Function
REQ-019 Beat base index SHALL be addr register index with low log2(NLANES) bits forced to 0; lane k SHALL address register base+k.
REQ-020 With en=1, each asserted we bit SHALL update that byte of an RW register at the next clock edge.
REQ-021 Pulse-mode registers SHALL store nothing: pul_val bits SHALL equal written data bits (for enabled bytes) for exactly one cycle after the write edge, otherwise 0; reg_val for them SHALL stay 0.
REQ-022 pul_val SHALL be 0 for non-pulse registers at all times.
REQ-023 W1C registers SHALL set a bit on hw_set bit=1 (sticky) and clear it on a write of 1 to that bit; written 0 SHALL have no effect.
REQ-024 Simultaneous hw_set and write-1-clear on the same W1C bit SHALL leave the bit set.
REQ-025 hw_set bits for non-W1C registers SHALL be ignored.
REQ-026 rd_data lane k SHALL return read_val[base+k] sampled at the en cycle, valid RD_LAT cycles after en, held until the next read.
REQ-027 Read and write in the same en cycle SHALL return pre-write read_val.
REQ-028 With en=0, rd_data, reg_val and W1C state (except hw_set) SHALL not change.
REQ-029 irq SHALL equal the OR of (reg_val[IRQ_STAT_IDX] AND reg_val[IRQ_EN_IDX]), registered one cycle.
REQ-030 Register indices beyond NREGS-1 do not exist; addr bits above NADDR+1 SHALL be ignored (aliasing wraps).

Reset
REQ-031 On axi_aresetn=0: RW registers = INIT_REG, W1C registers = 0, pul_val = 0, rd_data = 0, read pipeline cleared, irq = 0.
REQ-032 Reset mid-access SHALL discard in-flight reads and the pending write; first post-reset access SHALL behave normally.

Structure
REQ-033 Package regfile_pkg SHALL hold the 32-bit word typedef, lane-count constants and register-mode enum (RW, PULSE, W1C).
REQ-034 One sub-module, regfile_rd_pipe, SHALL implement the RD_LAT-deep read data pipeline.

Verification
REQ-035 NLANES=4: write addr 0x10, we=0xFFFF, data lanes {4,3,2,1} -> reg_val[4..7]={1,2,3,4}; read 0x10 with read_val=reg_val -> rd_data same after RD_LAT.
REQ-036 Byte enable: we=0x0002 writing 0xAABBCCDD to reg 0 (INIT 0) -> reg_val[0]=0x0000CC00.
REQ-037 PULSE_MASK bit 5: write 0x81 to reg 5 -> pul_val[5]=0x81 for one cycle, then 0; reg_val[5]=0.
REQ-038 W1C reg 3: hw_set[3]=0x4 -> bit stays; write 0x4 with hw_set 0x4 same cycle -> still 0x4; write 0x4 alone -> 0.
REQ-039 IRQ: reg 4 = 0x4, hw_set[3]=0x4 -> irq=1 one cycle after status sets; clear -> irq=0 next cycle.
REQ-040 Assert axi_aresetn low during RD_LAT=2 read -> rd_data=0, all registers at reset values, no stale read data after release.
